// File: rtl/bidir_mod_counter.sv
// bidir_mod_counter: up/down counter with programmable modulus (0..MOD_MAX),
// wrap or saturate at the limits, synchronous clear/load and count enable.
//
// Parameters: WIDTH (>=2), MOD_MAX (1..2**WIDTH-1), SAT_MODE (0 wrap, 1 saturate),
//             PRESCALE (>=1, divide ratio on en; used only with UDCTR_PRESCALE_EN).
// Build macro: UDCTR_PRESCALE_EN enables the en prescaler.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous reset, active-high
//   clr     synchronous clear (highest priority)
//   load    synchronous load of l_data, clamped to MOD_MAX
//   en      count enable
//   dir     1 = up, 0 = down
//   l_data  load value
//   ctr     registered count
//   tc_up   combinational, ctr == MOD_MAX
//   tc_dn   combinational, ctr == 0
//   ovf     registered one-cycle pulse after an up-step at MOD_MAX
//   unf     registered one-cycle pulse after a down-step at 0
module bidir_mod_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MOD_MAX  = 255,
  parameter int unsigned SAT_MODE = 0,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic             dir,
  input  logic [WIDTH-1:0] l_data,
  output logic [WIDTH-1:0] ctr,
  output logic             tc_up,
  output logic             tc_dn,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD_MAX);
  localparam bit SAT = (SAT_MODE != 0);
  localparam bit PARAMS_OK = (WIDTH >= 2) && (MOD_MAX >= 1) &&
                             (MOD_MAX <= (2 ** WIDTH) - 1) && (PRESCALE >= 1);

  // Elaboration-time guard against illegal parameter combinations
  if (!PARAMS_OK) begin : g_bad_params
    $error("bidir_mod_counter: illegal parameter combination");
  end

  logic             step_c;
  logic [WIDTH-1:0] ctr_nxt_c;
  logic             ovf_nxt_c;
  logic             unf_nxt_c;

`ifdef UDCTR_PRESCALE_EN
  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps;

  // Counter advances only on the en cycle that completes a prescale period
  assign step_c = en && (ps == PS_LAST);

  // Prescaler: zeroed by clr/load, frozen while en is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps <= '0;
    end else if (clr || load) begin
      ps <= '0;
    end else if (en) begin
      ps <= (ps == PS_LAST) ? '0 : ps + PS_W'(1);
    end
  end
`else
  assign step_c = en;
`endif

  // Next-state: clr > load > step
  always_comb begin
    ctr_nxt_c = ctr;
    ovf_nxt_c = 1'b0;
    unf_nxt_c = 1'b0;
    if (clr) begin
      ctr_nxt_c = '0;
    end else if (load) begin
      ctr_nxt_c = (l_data > MAX_V) ? MAX_V : l_data;
    end else if (step_c) begin
      if (dir) begin
        if (ctr == MAX_V) begin
          ovf_nxt_c = 1'b1;
          ctr_nxt_c = SAT ? ctr : '0;
        end else begin
          ctr_nxt_c = ctr + WIDTH'(1);
        end
      end else begin
        if (ctr == '0) begin
          unf_nxt_c = 1'b1;
          ctr_nxt_c = SAT ? ctr : MAX_V;
        end else begin
          ctr_nxt_c = ctr - WIDTH'(1);
        end
      end
    end
  end

  // Count and event-pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ctr <= ctr_nxt_c;
      ovf <= ovf_nxt_c;
      unf <= unf_nxt_c;
    end
  end

  assign tc_up = (ctr == MAX_V);
  assign tc_dn = (ctr == '0);

endmodule

// File: tb/tb_bidir_mod_counter.sv
// Directed self-checking bench for bidir_mod_counter.
// Three instances share the stimulus: wrap (w), saturate (s) and a
// PRESCALE=4 instance (p) that only matters when UDCTR_PRESCALE_EN is set.
module tb_bidir_mod_counter;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         clr;
  logic         load;
  logic         en;
  logic         dir;
  logic [W-1:0] l_data;

  logic [W-1:0] ctr_w, ctr_s, ctr_p;
  logic         tc_up_w, tc_dn_w, ovf_w, unf_w;
  logic         tc_up_s, tc_dn_s, ovf_s, unf_s;
  logic         tc_up_p, tc_dn_p, ovf_p, unf_p;

  int checks;
  int errors;

  bidir_mod_counter #(.WIDTH(W), .MOD_MAX(9), .SAT_MODE(0), .PRESCALE(1)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .en(en), .dir(dir), .l_data(l_data),
    .ctr(ctr_w), .tc_up(tc_up_w), .tc_dn(tc_dn_w), .ovf(ovf_w), .unf(unf_w)
  );

  bidir_mod_counter #(.WIDTH(W), .MOD_MAX(9), .SAT_MODE(1), .PRESCALE(1)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .en(en), .dir(dir), .l_data(l_data),
    .ctr(ctr_s), .tc_up(tc_up_s), .tc_dn(tc_dn_s), .ovf(ovf_s), .unf(unf_s)
  );

  bidir_mod_counter #(.WIDTH(W), .MOD_MAX(9), .SAT_MODE(0), .PRESCALE(4)) u_ps (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .en(en), .dir(dir), .l_data(l_data),
    .ctr(ctr_p), .tc_up(tc_up_p), .tc_dn(tc_dn_p), .ovf(ovf_p), .unf(unf_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_p [8];
`ifdef UDCTR_PRESCALE_EN
    exp_p = '{0, 0, 0, 1, 1, 1, 1, 2};
`else
    exp_p = '{1, 2, 3, 4, 5, 6, 7, 8};
`endif
    checks = 0;
    errors = 0;
    rst = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; dir = 1'b1; l_data = '0;
    tick(); tick();
    check("rst_ctr",   32'(ctr_w),   0);
    check("rst_tc_dn", 32'(tc_dn_w), 1);
    check("rst_tc_up", 32'(tc_up_w), 0);
    check("rst_ovf",   32'(ovf_w),   0);
    check("rst_unf",   32'(unf_w),   0);

    // Load 5, then async reset between edges
    rst = 1'b0; load = 1'b1; l_data = 4'd5;
    tick();
    load = 1'b0;
    check("load5", 32'(ctr_w), 5);
    #2 rst = 1'b1;
    #1;
    check("async_rst_ctr",   32'(ctr_w),   0);
    check("async_rst_tc_dn", 32'(tc_dn_w), 1);
    rst = 1'b0; en = 1'b1; dir = 1'b1;
    tick();
    check("first_up", 32'(ctr_w), 1);

    // Wrap past MOD_MAX from 8
    en = 1'b0; load = 1'b1; l_data = 4'd8;
    tick();
    check("load8", 32'(ctr_w), 8);
    load = 1'b0; en = 1'b1; dir = 1'b1;
    tick();
    check("up_9",     32'(ctr_w), 9);
    check("up_9_ovf", 32'(ovf_w), 0);
    check("up_9_tc",  32'(tc_up_w), 1);
    tick();
    check("wrap_0",     32'(ctr_w), 0);
    check("wrap_0_ovf", 32'(ovf_w), 1);
    tick();
    check("up_1",     32'(ctr_w), 1);
    check("up_1_ovf", 32'(ovf_w), 0);

    // Underflow wrap from 0
    en = 1'b0; clr = 1'b1;
    tick();
    check("clr_0", 32'(ctr_w), 0);
    clr = 1'b0; en = 1'b1; dir = 1'b0;
    tick();
    check("dn_wrap_9",   32'(ctr_w), 9);
    check("dn_wrap_unf", 32'(unf_w), 1);
    en = 1'b0;
    tick();
    check("dn_hold_9",    32'(ctr_w), 9);
    check("unf_one_shot", 32'(unf_w), 0);

    // Load clamp
    load = 1'b1; l_data = 4'd15;
    tick();
    load = 1'b0;
    check("clamp_w",    32'(ctr_w),   9);
    check("clamp_tc",   32'(tc_up_w), 1);
    check("clamp_s",    32'(ctr_s),   9);

    // Saturating instance holds at MOD_MAX and repeats ovf
    en = 1'b1; dir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_up_ctr", 32'(ctr_s), 9);
      check("sat_up_ovf", 32'(ovf_s), 1);
    end
    check("wrap_side_2", 32'(ctr_w), 2);
    en = 1'b0; clr = 1'b1;
    tick();
    check("sat_clr_ovf", 32'(ovf_s), 0);
    clr = 1'b0; en = 1'b1; dir = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("sat_dn_ctr", 32'(ctr_s), 0);
      check("sat_dn_unf", 32'(unf_s), 1);
    end
    en = 1'b0;
    tick();
    check("sat_unf_drop", 32'(unf_s), 0);

    // Priority: clr > load > en
    clr = 1'b1; load = 1'b1; en = 1'b1; dir = 1'b1; l_data = 4'd3;
    tick();
    check("clr_beats_all", 32'(ctr_w), 0);
    clr = 1'b0;
    tick();
    check("load_beats_en", 32'(ctr_w), 3);
    load = 1'b0; dir = 1'b0;
    tick();
    check("dn_2", 32'(ctr_w), 2);
    en = 1'b0;
    tick();
    check("en0_hold", 32'(ctr_w), 2);

    // Prescaled instance from a clean start
    clr = 1'b1;
    tick();
    check("ps_clr", 32'(ctr_p), 0);
    clr = 1'b0; en = 1'b1; dir = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("ps_edge%0d", i + 1), 32'(ctr_p), 32'(exp_p[i]));
    end
    en = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
